// File: rtl/mips_fwd_pkg.sv
// Shared types and select codes for the EX-stage forwarding and load-use hazard logic.
package mips_fwd_pkg;

  // Width of the register numbers held in the shadow pipeline
  localparam int STAGE_AW = 5;

  // ALU operand select codes; 2'b11 is never produced
  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  typedef enum logic {
    HZ_RUN,
    HZ_STALL
  } hz_state_t;

  // Destination info carried down the shadow pipeline, one copy per stage
  typedef struct packed {
    logic [STAGE_AW-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } stage_info_t;

  // True when a stage writes a real register (never $0) that matches src
  function automatic logic dest_match(input stage_info_t info,
                                      input logic [STAGE_AW-1:0] src);
    return info.reg_write && (info.rd != '0) && (info.rd == src);
  endfunction

endpackage

// File: rtl/forwarding_hazard_unit_fwd_select.sv
// Forwarding select for one ALU operand: the MEM-stage producer beats the WB-stage one.
module fwd_select
  import mips_fwd_pkg::*;
(
  input  stage_info_t         mem_info,
  input  stage_info_t         wb_info,
  input  logic [STAGE_AW-1:0] src,
  output logic [1:0]          fwd
);

  // Newest producer wins; fall back to the register file value
  always_comb begin
    fwd = FWD_REG;
    if (dest_match(mem_info, src)) begin
      fwd = FWD_EX_MEM;
    end else if (dest_match(wb_info, src)) begin
      fwd = FWD_MEM_WB;
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding select and load-use stall control for a 5-stage MIPS pipeline.
// Tracks EX/MEM/WB destination info in its own shadow pipeline fed from ID fields.
// Optional: define HAZ_PERF_CNT_EN to add the saturating stall_cycles counter port.
// REG_AW must equal mips_fwd_pkg::STAGE_AW, since the shadow stages use the package struct.
module forwarding_hazard_unit
  import mips_fwd_pkg::*;
#(
  parameter int LOAD_USE_STALLS = 1,
  parameter int REG_AW          = STAGE_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  // Remaining stall cycles loaded when a multi-cycle load-use stall begins
  localparam logic [1:0] STALL_RELOAD = 2'(LOAD_USE_STALLS - 1);

  stage_info_t       ex_q;
  stage_info_t       mem_q;
  stage_info_t       wb_q;
  logic [REG_AW-1:0] ex_rs_q;
  logic [REG_AW-1:0] ex_rt_q;
  hz_state_t         state_q;
  logic [1:0]        cnt_q;
  logic              hz;
  logic              stall;

  // Load in EX whose destination is read by the instruction in ID
  always_comb begin
    hz = ex_q.mem_read && (ex_q.rd != '0) &&
         ((ex_q.rd == id_rs) || (id_rt_used && (ex_q.rd == id_rt)));
  end

  // A flush squashes the consumer, so it always overrides a stall
  always_comb begin
    stall = !flush && (((state_q == HZ_RUN) && hz) || (state_q == HZ_STALL));
  end

  assign pc_write    = !stall;
  assign ifid_write  = !stall;
  assign idex_bubble = stall | flush;

  // Shadow pipeline advance; EX takes a bubble while stalling or flushing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      ex_rs_q <= '0;
      ex_rt_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (stall || flush) begin
        ex_q    <= '0;
        ex_rs_q <= '0;
        ex_rt_q <= '0;
      end else begin
        ex_q    <= '{rd: id_rd_dest, reg_write: id_reg_write, mem_read: id_mem_read};
        ex_rs_q <= id_rs;
        ex_rt_q <= id_rt;
      end
    end
  end

  // RUN/STALL sequencer: the first stall cycle is issued from RUN, the rest from STALL
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HZ_RUN;
      cnt_q   <= 2'd0;
    end else if (flush) begin
      state_q <= HZ_RUN;
      cnt_q   <= 2'd0;
    end else begin
      case (state_q)
        HZ_RUN: begin
          if (hz && (LOAD_USE_STALLS > 1)) begin
            state_q <= HZ_STALL;
            cnt_q   <= STALL_RELOAD;
          end
        end
        HZ_STALL: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_q <= HZ_RUN;
          end
        end
        default: begin
          state_q <= HZ_RUN;
          cnt_q   <= 2'd0;
        end
      endcase
    end
  end

  fwd_select u_fwd_a (
    .mem_info (mem_q),
    .wb_info  (wb_q),
    .src      (ex_rs_q),
    .fwd      (ForwardA)
  );

  fwd_select u_fwd_b (
    .mem_info (mem_q),
    .wb_info  (wb_q),
    .src      (ex_rt_q),
    .fwd      (ForwardB)
  );

`ifdef HAZ_PERF_CNT_EN
  // Saturating count of cycles in which the pipeline front end was held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
